cosim_reg_write_collector: RTL

- Upstream feeder of the co-simulation register-write comparator.
- Accepts per-instruction register-write records from the core's retire path, in the same key format Spike uses: 4-bit type plus 60-bit id, 128-bit value.
- Groups the records per retired instruction and buffers them in a FIFO.
- Presents them one record per cycle with an end-of-instruction marker, so the comparator can match each instruction against Spike's write log.

---
 rtl/cosim_reg_write_collector.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cosim_reg_write_collector.sv
// Collects per-instruction register-write records from the retire path and
// presents them one per cycle, with an end-of-instruction marker, to the co-sim comparator.
module cosim_reg_write_collector #(
   parameter int DEPTH          = 8,
   parameter int XREG_W         = 64,
   parameter int FREG_W         = 128,
   parameter int REG_KEY_ID_W   = 60,
   parameter int REG_KEY_TYPE_W = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      wr_valid_i,
   output logic                      wr_ready_o,
   input  logic [REG_KEY_TYPE_W-1:0] wr_key_type_i,
   input  logic [REG_KEY_ID_W-1:0]   wr_key_id_i,
   input  logic [FREG_W-1:0]         wr_data_i,
   input  logic                      commit_valid_i,
   output logic                      commit_ready_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [REG_KEY_TYPE_W-1:0] out_key_type_o,
   output logic [REG_KEY_ID_W-1:0]   out_key_id_o,
   output logic [FREG_W-1:0]         out_data_o,
   output logic                      out_last_o,
   output logic                      out_nowr_o,
   output logic [63:0]               retire_cnt_o,
   output logic                      err_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [REG_KEY_TYPE_W-1:0] key_type;
      logic [REG_KEY_ID_W-1:0]   key_id;
      logic [FREG_W-1:0]         data;
      logic                      last;
      logic                      nowr;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          pend_q, pend_d;
   logic            pend_valid_q, pend_valid_d;
   logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]   count_q;
   logic [63:0]     retire_cnt_q;
   logic            err_q, err_d;

   logic            ready, w_acc, c_acc, pop;
   logic            push0_v, push1_v;
   entry_t          push0, push1, w_entry, head;
   logic [1:0]      n_push;

   // Two free slots are required because one cycle can push both the pending and the new record.
   assign ready          = (count_q <= CW'(DEPTH - 2)) && !rst_i;
   assign wr_ready_o     = ready;
   assign commit_ready_o = ready;
   assign w_acc          = wr_valid_i && ready;
   assign c_acc          = commit_valid_i && ready;

   assign head        = mem_q[rd_ptr_q];
   assign out_valid_o = (count_q != '0);
   assign pop         = out_valid_o && out_ready_i;

   assign out_key_type_o = out_valid_o ? head.key_type : '0;
   assign out_key_id_o   = out_valid_o ? head.key_id   : '0;
   assign out_data_o     = out_valid_o ? head.data     : '0;
   assign out_last_o     = out_valid_o && head.last;
   assign out_nowr_o     = out_valid_o && head.nowr;
   assign retire_cnt_o   = retire_cnt_q;
   assign err_o          = err_q;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      w_entry          = '0;
      w_entry.key_type = wr_key_type_i;
      w_entry.key_id   = wr_key_id_i;
      w_entry.data     = wr_data_i;
      w_entry.last     = 1'b1;
      push0_v          = 1'b0;
      push1_v          = 1'b0;
      push0            = pend_q;
      push1            = w_entry;
      pend_d           = pend_q;
      pend_valid_d     = pend_valid_q;
      err_d            = err_q;

      if (w_acc && !c_acc) begin
         push0_v      = pend_valid_q;
         push0.last   = 1'b0;
         pend_d       = w_entry;
         pend_valid_d = 1'b1;
      end else if (w_acc && c_acc) begin
         if (pend_valid_q) begin
            push0_v    = 1'b1;
            push0.last = 1'b0;
            push1_v    = 1'b1;
         end else begin
            push0_v = 1'b1;
            push0   = w_entry;
         end
         pend_valid_d = 1'b0;
      end else if (c_acc) begin
         push0_v = 1'b1;
         if (pend_valid_q) begin
            push0.last = 1'b1;
         end else begin
            push0      = '0;
            push0.last = 1'b1;
            push0.nowr = 1'b1;
         end
         pend_valid_d = 1'b0;
      end

      if (w_acc) begin
         if (!(wr_key_type_i inside {REG_KEY_TYPE_W'(0), REG_KEY_TYPE_W'(1),
                                     REG_KEY_TYPE_W'(2), REG_KEY_TYPE_W'(4)}))
            err_d = 1'b1;
         if (wr_key_type_i == '0 &&
             (wr_data_i[FREG_W-1:XREG_W] != '0 || wr_key_id_i == '0))
            err_d = 1'b1;
      end
   end

   assign n_push = {1'b0, push0_v} + {1'b0, push1_v};

   // NOTE: storage is left unreset; the cleared occupancy counter already marks every slot invalid.
   always_ff @(posedge clk_i) begin
      if (push0_v) mem_q[wr_ptr_q] <= push0;
      if (push1_v) mem_q[wr_ptr_q + AW'(1)] <= push1;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         retire_cnt_q <= '0;
         err_q        <= 1'b0;
      end else begin
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         wr_ptr_q     <= wr_ptr_q + AW'(n_push);
         rd_ptr_q     <= rd_ptr_q + AW'(pop);
         count_q      <= count_q + CW'(n_push) - CW'(pop);
         if (pop && head.last) retire_cnt_q <= retire_cnt_q + 64'd1;
         err_q        <= err_d;
      end
   end

endmodule
